seq_alu: RTL and testbench
==========================

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 16: operand and result width in bits; legal range 4..32.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 alu_op  input  3  operation select, latched with start.
REQ-006 in1  input  WIDTH  operand 1 (divisor for DIV/MOD), latched with start.
REQ-007 in2  input  WIDTH  operand 2 (dividend for DIV/MOD), latched with start.
REQ-008 alu_out  output  WIDTH  registered result; holds until the next completion.
REQ-009 busy  output  1  high while an operation is in progress; low in IDLE.
REQ-010 done  output  1  one-cycle pulse when alu_out is updated.
REQ-011 z  output  1  registered; high when the completed alu_out equals 0.
REQ-012 dz  output  1  registered; high when the completed DIV/MOD had in1 == 0.

Function
REQ-013 The block SHALL implement a state machine with states IDLE, MUL, DIV and DONE.
REQ-014 Opcodes: 0 ADD in1+in2; 1 SUB in1-in2; 2 MUL in1*in2; 3 DIV in2/in1; 4 PASS in2; 5 MOD in2%in1; 6 and 7 execute as ADD.
REQ-015 All arithmetic is unsigned, modulo 2^WIDTH; MUL returns the low WIDTH bits of the product.
REQ-016 Single-cycle ops (ADD, SUB, PASS, 6, 7): start in IDLE at edge k writes alu_out/z at edge k; the FSM goes to DONE; done is high for the cycle after edge k.
REQ-017 MUL: start at edge k latches operands and enters MUL; shift-add runs one bit per edge, edges k+1..k+WIDTH; the result is written at edge k+WIDTH; the FSM then enters DONE.
REQ-018 DIV/MOD with in1 != 0: start at edge k enters DIV; restoring division runs one bit per edge, edges k+1..k+WIDTH; alu_out (quotient or remainder) is written at edge k+WIDTH; the FSM enters DONE.
REQ-019 DIV/MOD with in1 == 0: no iteration; at edge k alu_out = all-ones (DIV) or in2 (MOD), dz = 1, FSM to DONE.
REQ-020 dz SHALL be 0 after any completion other than REQ-019.
REQ-021 DONE: done = 1, busy = 0; the next edge returns the FSM to IDLE.
REQ-022 busy SHALL be 1 in MUL and DIV only; done and busy are never both 1.
REQ-023 start in MUL, DIV or DONE is ignored: no latch, no effect on the operation in progress.
REQ-024 Operand/opcode changes after the start edge do not affect the result.
REQ-025 alu_out, z and dz change only at a completion edge or at reset.

Reset
REQ-026 rst high at an edge forces IDLE, alu_out = 0, z = 0, dz = 0, busy = 0, done = 0, and clears the iteration counter and datapath registers.
REQ-027 rst has priority over start; rst during MUL/DIV aborts the operation with no done pulse.
REQ-028 The first start after rst deasserts is accepted normally.

Verification (WIDTH = 16)
REQ-029 Case 1: ADD in1=0x7FFF, in2=0x0001 -> alu_out=0x8000, z=0, done 1 cycle after start; then SUB 5-5 -> 0x0000, z=1.
REQ-030 Case 2: MUL 300*300 -> alu_out=0x5F90; busy high for exactly 16 cycles; done exactly 16 cycles after the ADD-case timing.
REQ-031 Case 3: DIV in2=100, in1=7 -> alu_out=14, dz=0; MOD on the same operands -> 2; MOD 0xFFFF%0x0001 -> 0, z=1.
REQ-032 Case 4: DIV in2=1234, in1=0 -> alu_out=0xFFFF, dz=1, busy never high; MOD on the same operands -> 1234, dz=1.
REQ-033 Case 5: start MUL 3*4; during busy, apply start with PASS 0xAAAA -> result 12, single done pulse, PASS never executed.
REQ-034 Case 6: rst at cycle 5 of a DIV -> no done; all outputs 0 next cycle; then ADD 2+2 -> 4.

Source files
------------

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle add/sub/pass, WIDTH-cycle shift-add multiply,
// and WIDTH-cycle restoring divide/modulo with a divide-by-zero flag.
module seq_alu #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic [WIDTH-1:0] alu_out,
  output logic             busy,
  output logic             done,
  output logic             z,
  output logic             dz
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_MUL  = 3'd2;
  localparam logic [2:0] OP_DIV  = 3'd3;
  localparam logic [2:0] OP_PASS = 3'd4;
  localparam logic [2:0] OP_MOD  = 3'd5;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] alu_out_q, alu_out_d;
  logic             z_q, z_d;
  logic             dz_q, dz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             is_mod_q, is_mod_d;
  // a: multiplicand / divisor; b: multiplier / dividend-quotient; acc: product / remainder
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] quick_res;
  logic [WIDTH-1:0] mul_sum;
  logic [WIDTH:0]   rem_sh;
  logic             rem_geq;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      alu_out_q <= '0;
      z_q       <= 1'b0;
      dz_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      is_mod_q  <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      alu_out_q <= alu_out_d;
      z_q       <= z_d;
      dz_q      <= dz_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      is_mod_q  <= is_mod_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    alu_out_d = alu_out_q;
    z_d       = z_q;
    dz_d      = dz_q;
    is_mod_d  = is_mod_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;

    case (alu_op)
      OP_SUB:  quick_res = in1 - in2;
      OP_PASS: quick_res = in2;
      default: quick_res = in1 + in2;
    endcase

    mul_sum = acc_q + (b_q[0] ? a_q : '0);
    rem_sh  = {acc_q, b_q[WIDTH-1]};
    rem_geq = (rem_sh >= {1'b0, a_q});

    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (alu_op)
            OP_MUL: begin
              a_d     = in1;
              b_d     = in2;
              acc_d   = '0;
              cnt_d   = '0;
              state_d = S_MUL;
            end
            OP_DIV, OP_MOD: begin
              if (in1 == '0) begin
                alu_out_d = (alu_op == OP_DIV) ? '1 : in2;
                z_d       = (alu_op == OP_MOD) && (in2 == '0);
                dz_d      = 1'b1;
                state_d   = S_DONE;
              end else begin
                a_d      = in1;
                b_d      = in2;
                acc_d    = '0;
                cnt_d    = '0;
                is_mod_d = (alu_op == OP_MOD);
                state_d  = S_DIV;
              end
            end
            default: begin
              alu_out_d = quick_res;
              z_d       = (quick_res == '0);
              dz_d      = 1'b0;
              state_d   = S_DONE;
            end
          endcase
        end
      end
      S_MUL: begin
        acc_d = mul_sum;
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          alu_out_d = mul_sum;
          z_d       = (mul_sum == '0);
          dz_d      = 1'b0;
          state_d   = S_DONE;
        end
      end
      S_DIV: begin
        acc_d = rem_geq ? WIDTH'(rem_sh - {1'b0, a_q}) : WIDTH'(rem_sh);
        b_d   = {b_q[WIDTH-2:0], rem_geq};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          alu_out_d = is_mod_q ? acc_d : b_d;
          z_d       = (alu_out_d == '0);
          dz_d      = 1'b0;
          state_d   = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Status flags are registered versions of the upcoming state.
    busy_d = (state_d == S_MUL) || (state_d == S_DIV);
    done_d = (state_d == S_DONE);
  end

  assign alu_out = alu_out_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign z       = z_q;
  assign dz      = dz_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed + short random bench for seq_alu (WIDTH = 16) with a queue scoreboard.
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  alu_op;
  logic [15:0] in1;
  logic [15:0] in2;
  logic [15:0] alu_out;
  logic        busy;
  logic        done;
  logic        z;
  logic        dz;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [15:0] out;
    logic        z;
    logic        dz;
    int          lat;
    int          bsy;
  } exp_t;

  exp_t sb[$];

  seq_alu #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .alu_op(alu_op), .in1(in1), .in2(in2),
    .alu_out(alu_out), .busy(busy), .done(done), .z(z), .dz(dz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour: in1 is the divisor, in2 the dividend.
  function automatic exp_t model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    logic [31:0] prod;
    e.dz  = 1'b0;
    e.lat = 1;
    e.bsy = 0;
    case (op)
      3'd1: e.out = a - b;
      3'd2: begin
        prod  = {16'h0, a} * {16'h0, b};
        e.out = prod[15:0];
        e.lat = 17;
        e.bsy = 16;
      end
      3'd3, 3'd5: begin
        if (a == 16'h0) begin
          e.out = (op == 3'd3) ? 16'hFFFF : b;
          e.dz  = 1'b1;
        end else begin
          e.out = (op == 3'd3) ? (b / a) : (b % a);
          e.lat = 17;
          e.bsy = 16;
        end
      end
      3'd4: e.out = b;
      default: e.out = a + b;
    endcase
    e.z = (e.out == 16'h0);
    return e;
  endfunction

  // Issue one op, optionally attempt a PASS start while busy, then check the completion.
  task automatic do_op(input string tag, input logic [2:0] op, input logic [15:0] a,
                       input logic [15:0] b, input bit inj);
    exp_t ex;
    int   n;
    int   bcnt;
    bit   got;
    sb.push_back(model(op, a, b));
    @(negedge clk);
    alu_op = op; in1 = a; in2 = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; in1 = 16'($urandom); in2 = 16'($urandom); alu_op = 3'($urandom);
    n = 1; bcnt = 0; got = 1'b0;
    while (!got && n <= 100) begin
      if (busy) bcnt++;
      chk({tag, "_busy_and_done"}, 32'(busy & done), 32'd0);
      if (done) begin
        got = 1'b1;
        ex  = sb.pop_front();
        chk({tag, "_out"}, 32'(alu_out), 32'(ex.out));
        chk({tag, "_z"}, 32'(z), 32'(ex.z));
        chk({tag, "_dz"}, 32'(dz), 32'(ex.dz));
        chk({tag, "_latency"}, 32'(n), 32'(ex.lat));
        chk({tag, "_busy_cycles"}, 32'(bcnt), 32'(ex.bsy));
      end else begin
        if (inj && n == 3) begin
          start = 1'b1; alu_op = 3'd4; in2 = 16'hAAAA;
        end else if (inj && n == 4) begin
          start = 1'b0;
        end
        n++;
        @(negedge clk);
      end
    end
    chk({tag, "_completed"}, 32'(got), 32'd1);
    if (!got && sb.size() > 0) ex = sb.pop_front();
    @(negedge clk);
    chk({tag, "_single_done"}, 32'(done), 32'd0);
    chk({tag, "_busy_after"}, 32'(busy), 32'd0);
    if (got) chk({tag, "_out_hold"}, 32'(alu_out), 32'(ex.out));
  endtask

  initial begin
    logic [2:0]  rop;
    logic [15:0] ra;
    rst = 1'b1; start = 1'b0; alu_op = 3'd0; in1 = 16'h0; in2 = 16'h0;
    repeat (3) @(negedge clk);
    chk("reset_out", 32'(alu_out), 32'd0);
    chk("reset_z", 32'(z), 32'd0);
    chk("reset_dz", 32'(dz), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    rst = 1'b0;

    do_op("add_7fff_1", 3'd0, 16'h7FFF, 16'h0001, 1'b0);
    do_op("sub_5_5", 3'd1, 16'd5, 16'd5, 1'b0);
    do_op("mul_300_300", 3'd2, 16'd300, 16'd300, 1'b0);
    do_op("div_100_7", 3'd3, 16'd7, 16'd100, 1'b0);
    do_op("mod_100_7", 3'd5, 16'd7, 16'd100, 1'b0);
    do_op("mod_ffff_1", 3'd5, 16'h0001, 16'hFFFF, 1'b0);
    do_op("div_by_zero", 3'd3, 16'd0, 16'd1234, 1'b0);
    do_op("mod_by_zero", 3'd5, 16'd0, 16'd1234, 1'b0);
    do_op("mul_3_4_ignore_start", 3'd2, 16'd3, 16'd4, 1'b1);
    do_op("op6_add", 3'd6, 16'hFFFF, 16'h0002, 1'b0);
    do_op("op7_add", 3'd7, 16'h1234, 16'h1111, 1'b0);
    do_op("div_ffff_1", 3'd3, 16'h0001, 16'hFFFF, 1'b0);

    for (int i = 0; i < 8; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = (i % 4 == 3) ? 16'h0 : 16'($urandom);
      do_op($sformatf("rand%0d_op%0d", i, rop), rop, ra, 16'($urandom), 1'b0);
    end

    // Leave nonzero alu_out and dz=1 behind so the reset clear is visible.
    do_op("mod_by_zero_pre_rst", 3'd5, 16'd0, 16'd1234, 1'b0);
    @(negedge clk);
    alu_op = 3'd3; in1 = 16'd7; in2 = 16'd100; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      chk($sformatf("abort_busy_c%0d", c), 32'(busy), 32'd1);
      chk($sformatf("abort_no_done_c%0d", c), 32'(done), 32'd0);
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_rst_out", 32'(alu_out), 32'd0);
    chk("abort_rst_z", 32'(z), 32'd0);
    chk("abort_rst_dz", 32'(dz), 32'd0);
    chk("abort_rst_busy", 32'(busy), 32'd0);
    chk("abort_rst_done", 32'(done), 32'd0);
    for (int c = 0; c < 20; c++) begin
      chk($sformatf("abort_quiet_c%0d", c), 32'({busy, done}), 32'd0);
      @(negedge clk);
    end
    do_op("add_2_2_after_rst", 3'd0, 16'd2, 16'd2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
